// File: rtl/mul_iter.sv
// Multi-cycle shift-add integer multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes at accept; the sign is applied once in FIX.
module mul_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  Vj,
  input  logic [XLEN-1:0]  Vk,
  input  logic [1:0]       Op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  y,
  output logic [TAG_W-1:0] out_tag
);

  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = XLEN + BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_reg, state_next;
  logic [XLEN-1:0]     mag_j_reg, mag_j_next;
  logic [XLEN-1:0]     mag_k_reg, mag_k_next;
  logic                neg_reg, neg_next;
  logic [1:0]          op_reg, op_next;
  logic [TAG_W-1:0]    tag_reg, tag_next;
  logic [2*XLEN-1:0]   acc_reg, acc_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [XLEN-1:0]     y_reg, y_next;
  logic [TAG_W-1:0]    out_tag_reg, out_tag_next;
  logic                out_valid_reg, out_valid_next;

  logic                accept;
  logic                sign_j, sign_k;
  logic [XLEN-1:0]     vj_mag, vk_mag;
  logic [PW-1:0]       pp [B];
  logic [PW-1:0]       psum;
  logic [2*XLEN-1:0]   psum_ext;
  logic [2*XLEN-1:0]   prod;

  assign in_ready  = rst_n && !flush &&
                     (state_reg == IDLE || (state_reg == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign y         = y_reg;
  assign out_tag   = out_tag_reg;

  assign sign_j = Vj[XLEN-1] && (Op == 2'b01 || Op == 2'b10);
  assign sign_k = Vk[XLEN-1] && (Op == 2'b01);
  assign vj_mag = sign_j ? -Vj : Vj;
  assign vk_mag = sign_k ? -Vk : Vk;

  // One shifted copy of |Vj| per multiplier bit consumed this cycle.
  for (genvar gi = 0; gi < B; gi++) begin : g_pp
    assign pp[gi] = mag_k_reg[gi] ? (PW'(mag_j_reg) << gi) : '0;
  end

  always_comb begin
    psum = '0;
    for (int i = 0; i < B; i++) psum = psum + pp[i];
  end

  // Right-shifting accumulator: each new partial enters at bit XLEN-B and
  // has drifted down to its true weight once all N steps are done.
  assign psum_ext = (2*XLEN)'(psum) << (XLEN - B);
  assign prod     = neg_reg ? -acc_reg : acc_reg;

  always_comb begin
    state_next     = state_reg;
    mag_j_next     = mag_j_reg;
    mag_k_next     = mag_k_reg;
    neg_next       = neg_reg;
    op_next        = op_reg;
    tag_next       = tag_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    y_next         = y_reg;
    out_tag_next   = out_tag_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      CALC: begin
        acc_next   = (acc_reg >> B) + psum_ext;
        mag_k_next = mag_k_reg >> B;
        cnt_next   = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) state_next = FIX;
      end
      FIX: begin
        y_next         = (op_reg == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        out_tag_next   = tag_reg;
        out_valid_next = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: ;
    endcase

    // in_ready already restricts this to IDLE or a completing DONE.
    if (accept) begin
      mag_j_next = vj_mag;
      mag_k_next = vk_mag;
      neg_next   = sign_j ^ sign_k;
      op_next    = Op;
      tag_next   = in_tag;
      acc_next   = '0;
      cnt_next   = CW'(N);
      state_next = CALC;
    end

    if (flush) begin
      state_next     = IDLE;
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mag_j_reg     <= '0;
      mag_k_reg     <= '0;
      neg_reg       <= 1'b0;
      op_reg        <= '0;
      tag_reg       <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      y_reg         <= '0;
      out_tag_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mag_j_reg     <= mag_j_next;
      mag_k_reg     <= mag_k_next;
      neg_reg       <= neg_next;
      op_reg        <= op_next;
      tag_reg       <= tag_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      y_reg         <= y_next;
      out_tag_reg   <= out_tag_next;
      out_valid_reg <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: a 32-bit/1-bit-per-cycle instance with
// directed vectors and a 64-bit/4-bit-per-cycle instance against a model.
module tb_mul_iter;

  localparam int N32 = 32;
  localparam int N64 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] y;
    logic [3:0]  tag;
    int          acc;
  } exp_t;
  exp_t q32[$];
  exp_t q64[$];

  // 32-bit instance
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] vj = '0, vk = '0;
  logic [1:0]  op = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid;
  logic [31:0] y;
  logic [3:0]  out_tag;

  mul_iter #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Vj(vj), .Vk(vk), .Op(op), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag));

  // 64-bit instance
  logic        w_in_valid = 1'b0, w_flush = 1'b0, w_out_ready = 1'b1;
  logic [63:0] w_vj = '0, w_vk = '0;
  logic [1:0]  w_op = '0;
  logic [3:0]  w_in_tag = '0;
  logic        w_in_ready, w_out_valid;
  logic [63:0] w_y;
  logic [3:0]  w_out_tag;

  mul_iter #(.XLEN(64), .BITS_PER_CYCLE(4), .TAG_W(4)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .Vj(w_vj), .Vk(w_vk), .Op(w_op), .in_tag(w_in_tag), .flush(w_flush),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .y(w_y), .out_tag(w_out_tag));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference via sign/zero extension to 128 bits.
  function automatic logic [63:0] ref64(logic [1:0] o, logic [63:0] a, logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{64{a[63]}}, a} : {64'h0, a};
    eb = (o == 2'b01) ? {{64{b[63]}}, b} : {64'h0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Monitors: pop and compare whenever a result handshake is presented.
  logic ov32_last = 1'b0, ov64_last = 1'b0;
  int   rise32 = 0, rise64 = 0;

  always @(negedge clk) begin
    if (out_valid && !ov32_last) rise32 = cyc;
    ov32_last = out_valid;
    if (out_valid && out_ready) begin
      if (q32.size() == 0) chk("unexpected_result32", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        $display("x32 tag=%0d y=%h", out_tag, y);
        chk("y32", 64'(y), e.y);
        chk("tag32", 64'(out_tag), 64'(e.tag));
        chk("latency32", 64'(rise32 - e.acc), 64'(N32 + 1));
      end
    end
  end

  always @(negedge clk) begin
    if (w_out_valid && !ov64_last) rise64 = cyc;
    ov64_last = w_out_valid;
    if (w_out_valid && w_out_ready) begin
      if (q64.size() == 0) chk("unexpected_result64", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q64.pop_front();
        $display("x64 tag=%0d y=%h", w_out_tag, w_y);
        chk("y64", w_y, e.y);
        chk("tag64", 64'(w_out_tag), 64'(e.tag));
        chk("latency64", 64'(rise64 - e.acc), 64'(N64 + 1));
      end
    end
  end

  task automatic send32(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [3:0] t,
                        logic [31:0] ey, bit push, output int waits);
    exp_t e;
    op = o; vj = a; vk = b; in_tag = t; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin waits++; @(negedge clk); end
    if (!in_ready) chk("accept_timeout32", 64'd0, 64'd1);
    else if (push) begin
      e.y = {32'h0, ey}; e.tag = t; e.acc = cyc + 1;
      q32.push_back(e);
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send64(logic [1:0] o, logic [63:0] a, logic [63:0] b, logic [3:0] t,
                        logic [63:0] ey, output int waits);
    exp_t e;
    w_op = o; w_vj = a; w_vk = b; w_in_tag = t; w_in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!w_in_ready && waits < 200) begin waits++; @(negedge clk); end
    if (!w_in_ready) chk("accept_timeout64", 64'd0, 64'd1);
    else begin
      e.y = ey; e.tag = t; e.acc = cyc + 1;
      q64.push_back(e);
    end
    @(posedge clk); #1 w_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 500) begin n++; @(negedge clk); end
    chk("drain", 64'(q32.size() + q64.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [1:0]  d_op [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
  logic [31:0] d_a  [9] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'h80000000,
                            32'h00010000};
  logic [31:0] d_b  [9] = '{32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h80000000, 32'h00000010, 32'h00000002,
                            32'h00030000};
  logic [31:0] d_y  [9] = '{32'h40000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF,
                            32'hFFFFFFFE, 32'h00000000, 32'h23456780, 32'hFFFFFFFF,
                            32'h00000003};

  initial begin
    int w;
    int seen;
    logic [63:0] ra, rb;
    logic [1:0]  ro;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // MUL 7*6 with consumer stalled for 5 cycles
    @(posedge clk); #1 out_ready = 1'b0;
    send32(2'b00, 32'd7, 32'd6, 4'd3, 32'h2A, 1'b1, w);
    seen = 0;
    while (!out_valid && seen < 100) begin seen++; @(negedge clk); end
    chk("first_valid_seen", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_y", 64'(y), 64'h2A);
    end
    @(posedge clk); #1 out_ready = 1'b1;

    // Directed vectors issued back-to-back
    for (int i = 0; i < 9; i++) begin
      send32(d_op[i], d_a[i], d_b[i], 4'(i + 4), d_y[i], 1'b1, w);
      if (i > 0) chk("b2b_busy_cycles", 64'(w), 64'(N32 + 1));
    end
    drain();

    // Flush in CALC with a competing request
    send32(2'b00, 32'd5, 32'd5, 4'hA, 32'd0, 1'b0, w);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1; op = 2'b00; vj = 32'd9; vk = 32'd9; in_tag = 4'hB;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_y_hold", 64'(y), 64'd3);
    chk("flush_tag_hold", 64'(out_tag), 64'd12);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("killed_never_valid", 64'(seen), 64'd0);
    @(posedge clk); #1;
    send32(2'b11, 32'hFFFFFFFF, 32'h2, 4'hC, 32'h1, 1'b1, w);
    drain();

    // Asynchronous reset mid-CALC
    send32(2'b01, 32'h80000000, 32'h1, 4'hD, 32'd0, 1'b0, w);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_y", 64'(y), 64'd0);
    chk("async_rst_tag", 64'(out_tag), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send32(2'b10, 32'h80000000, 32'h2, 4'h5, 32'hFFFFFFFF, 1'b1, w);
    drain();

    // 64-bit, 4 bits per cycle
    send64(2'b01, 64'h8000000000000000, 64'h8000000000000000, 4'h1, 64'h4000000000000000, w);
    send64(2'b00, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'h2, 64'h1, w);
    chk("b2b_busy_cycles64", 64'(w), 64'(N64 + 1));
    send64(2'b11, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'h3, 64'hFFFFFFFFFFFFFFFE, w);
    send64(2'b10, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'h4, 64'hFFFFFFFFFFFFFFFF, w);
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 3 == 0) rb = -64'($urandom_range(1, 1000));
      ro = 2'($urandom_range(0, 3));
      send64(ro, ra, rb, 4'(i), ref64(ro, ra, rb), w);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Parametrised multi-cycle integer multiplier for the RV M-extension execution unit. Successor to the single-cycle combinational multiplier.
- Computes MUL/MULH/MULHSU/MULHU over XLEN-bit operands Vj/Vk by shift-add, retiring BITS_PER_CYCLE multiplier bits per clock.
- Uses valid/ready handshakes on both sides, carries a reservation-station tag through to the result, and supports flush of an in-flight op.

Parameters:
- XLEN, 32, operand and result width; must be >= 8.
- BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle; must divide XLEN. N = XLEN/BITS_PER_CYCLE.
- TAG_W, 4, width of the tag carried with each op.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- Vj  in  XLEN  operand rs1.
- Vk  in  XLEN  operand rs2.
- Op  in  2  mode: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_tag  in  TAG_W  reservation-station tag.
- flush  in  1  synchronous kill of any in-flight or pending op.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, out_valid=0, y=0, out_tag=0, all internal registers 0. in_ready is 0 while rst_n=0 and is 1 in IDLE after release.
- FSM states: IDLE, CALC, FIX, DONE.
- Handshake:
  - Accept when in_valid && in_ready && !flush.
  - in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
  - Result handshake completes when out_valid && out_ready.
- Accept edge (E0), signedness by mode:
  - MULH: both operands signed.
  - MULHSU: Vj signed, Vk unsigned.
  - MUL, MULHU: both unsigned.
- Accept edge register contents: |Vj| and |Vk| as XLEN-bit unsigned magnitudes (|-2^(XLEN-1)| = 2^(XLEN-1) fits), neg = sign_j XOR sign_k (signed operands only), Op, in_tag. Clear the 2*XLEN accumulator; counter=N; go to CALC.
- CALC: each edge adds (magnitude_j * next BITS_PER_CYCLE bits of magnitude_k), shifted to the correct position, into the accumulator, then decrements the counter. After N edges go to FIX.
- FIX: one edge.
  - Conditional two's-complement negation of the 2*XLEN product when neg=1.
  - y = low XLEN bits for MUL, high XLEN bits otherwise; out_tag = stored tag.
  - Set out_valid=1; go to DONE.
- Latency: out_valid=1 after edge E(N+1). Default params give 33 edges.
- DONE: y/out_tag/out_valid held stable until handshake. On handshake with no new accept → IDLE, out_valid=0. On handshake with simultaneous accept → CALC with new op (back-to-back; throughput one op per N+2 cycles).
- flush=1 at any edge: state→IDLE, out_valid→0, no accept that cycle (flush beats in_valid). y and out_tag keep last values.
- Zero operands give result 0 (negation of 0 is 0). No overflow or exception signalling; MUL discards the high half.
- Op outside CALC/FIX is don't-care; only the value registered at accept is used.

Test Plan:
- MUL 7 × 6, tag=3 → out_valid exactly 33 edges after accept, y=0x0000002A, out_tag=3; out_valid held while out_ready=0 for 5 cycles, y unchanged.
- MULH 0x80000000 × 0x80000000 → y=0x40000000. MULH 0xFFFFFFFF × 0x00000002 → y=0xFFFFFFFF. MUL 0xFFFFFFFF × 0xFFFFFFFF → y=0x00000001.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → y=0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → y=0xFFFFFFFE.
- Back-to-back: second request with in_valid=1 held during DONE, out_ready=1 → same-edge accept. Second result out_valid N+2 edges later, tags in order. in_ready=0 throughout CALC/FIX.
- flush asserted in CALC cycle 10 with in_valid=1 → no accept that edge, state IDLE next edge, out_valid never rises for the killed op; next op completes normally.
- rst_n dropped mid-CALC (async, between edges) → out_valid=0, y=0, out_tag=0 immediately. After release, IDLE with in_ready=1. Repeat mixed-sign random ops at BITS_PER_CYCLE=4 and XLEN=64 against a reference model; latency = N+1 edges.
